// File: rtl/bf_core_if.sv
// Byte-stream handshake bundle between the core and the host I/O fabric.
// master = core side, slave = host side.
interface bf_core_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output out_data, out_valid, in_ready,
    input  out_ready, in_data, in_valid
  );

  modport slave (
    input  out_data, out_valid, in_ready,
    output out_ready, in_data, in_valid
  );
endinterface

// File: rtl/bf_core.sv
// Brainfuck execution core: fetches ASCII opcodes, operates on a data
// memory, resolves loops with a return stack plus a forward-skip scanner,
// and exchanges bytes with the host over valid/ready streams.
module bf_core #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DADDR_W     = 8,
  parameter int unsigned IADDR_W     = 8,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset_,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [7:0]         imem_data,
  output logic [DADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_wdata,
  bf_core_if.master          io,
  output logic               halted,
  output logic               error,
  output logic [1:0]         err_code
);

  localparam int unsigned SP_W = $clog2(STACK_DEPTH) + 1;

  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_OPEN  = 8'h5B;
  localparam logic [7:0] OP_CLOSE = 8'h5D;
  localparam logic [7:0] OP_HALT  = 8'h00;

  typedef enum logic [2:0] {
    S_RUN, S_SKIP, S_OUT_WAIT, S_IN_WAIT, S_HALT, S_ERR
  } state_t;

  state_t               r_state, w_state_nx;
  logic [IADDR_W-1:0]   r_ip, w_ip_nx;
  logic [DADDR_W-1:0]   r_dp, w_dp_nx;
  logic [SP_W-1:0]      r_sp;
  logic [IADDR_W-1:0]   r_stack [STACK_DEPTH];
  logic [IADDR_W:0]     r_depth, w_depth_nx;
  logic [DATA_W-1:0]    r_out_data;
  logic                 r_out_valid;
  logic                 r_in_ready;
  logic [1:0]           r_err_code, w_err_nx;

  logic                 w_push, w_pop;
  logic                 w_out_set, w_out_clr;
  logic                 w_in_set, w_in_clr;
  logic                 w_cell_nz;
  logic                 w_stack_full, w_stack_empty;
  logic [SP_W-2:0]      w_top_idx;
  logic [IADDR_W-1:0]   w_top;

  assign w_cell_nz     = |dmem_rdata;
  assign w_stack_full  = (r_sp == SP_W'(STACK_DEPTH));
  assign w_stack_empty = (r_sp == '0);
  assign w_top_idx     = r_sp[SP_W-2:0] - 1'b1;
  assign w_top         = r_stack[w_top_idx];

  assign imem_addr    = r_ip;
  assign dmem_addr    = r_dp;
  assign io.out_data  = r_out_data;
  assign io.out_valid = r_out_valid;
  assign io.in_ready  = r_in_ready;
  assign err_code     = r_err_code;

  // State register
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) r_state <= S_RUN;
    else         r_state <= w_state_nx;
  end

  // Next-state and datapath control decode
  always_comb begin
    w_state_nx = r_state;
    w_ip_nx    = r_ip;
    w_dp_nx    = r_dp;
    w_depth_nx = r_depth;
    w_err_nx   = r_err_code;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_out_set  = 1'b0;
    w_out_clr  = 1'b0;
    w_in_set   = 1'b0;
    w_in_clr   = 1'b0;
    unique case (r_state)
      S_RUN: begin
        w_ip_nx = r_ip + 1'b1;
        case (imem_data)
          OP_RIGHT: w_dp_nx = r_dp + 1'b1;
          OP_LEFT:  w_dp_nx = r_dp - 1'b1;
          OP_OUT: begin
            w_ip_nx    = r_ip;
            w_out_set  = 1'b1;
            w_state_nx = S_OUT_WAIT;
          end
          OP_IN: begin
            w_ip_nx    = r_ip;
            w_in_set   = 1'b1;
            w_state_nx = S_IN_WAIT;
          end
          OP_OPEN: begin
            if (!w_cell_nz) begin
              w_depth_nx = (IADDR_W+1)'(1);
              w_state_nx = S_SKIP;
            end else if (w_stack_full) begin
              w_ip_nx    = r_ip;
              w_err_nx   = 2'd1;
              w_state_nx = S_ERR;
            end else begin
              w_push = 1'b1;
            end
          end
          OP_CLOSE: begin
            if (w_stack_empty) begin
              w_ip_nx    = r_ip;
              w_err_nx   = 2'd2;
              w_state_nx = S_ERR;
            end else if (w_cell_nz) begin
              w_ip_nx = w_top + 1'b1;
            end else begin
              w_pop = 1'b1;
            end
          end
          OP_HALT: begin
            w_ip_nx    = r_ip;
            w_state_nx = S_HALT;
          end
          default: ;
        endcase
      end
      // The closing ']' is matched before the wrap check so a loop that
      // ends on the last address still resumes normally.
      S_SKIP: begin
        if (imem_data == OP_CLOSE && r_depth == (IADDR_W+1)'(1)) begin
          w_ip_nx    = r_ip + 1'b1;
          w_depth_nx = '0;
          w_state_nx = S_RUN;
        end else if (r_ip == '1) begin
          w_err_nx   = 2'd3;
          w_state_nx = S_ERR;
        end else begin
          w_ip_nx = r_ip + 1'b1;
          if (imem_data == OP_OPEN)  w_depth_nx = r_depth + 1'b1;
          if (imem_data == OP_CLOSE) w_depth_nx = r_depth - 1'b1;
        end
      end
      S_OUT_WAIT: begin
        if (io.out_ready) begin
          w_out_clr  = 1'b1;
          w_ip_nx    = r_ip + 1'b1;
          w_state_nx = S_RUN;
        end
      end
      S_IN_WAIT: begin
        if (io.in_valid) begin
          w_in_clr   = 1'b1;
          w_ip_nx    = r_ip + 1'b1;
          w_state_nx = S_RUN;
        end
      end
      default: ;
    endcase
  end

  // Memory write strobe and status outputs
  always_comb begin
    dmem_we    = 1'b0;
    dmem_wdata = dmem_rdata;
    if (r_state == S_RUN) begin
      if (imem_data == OP_INC) begin
        dmem_we    = 1'b1;
        dmem_wdata = dmem_rdata + 1'b1;
      end else if (imem_data == OP_DEC) begin
        dmem_we    = 1'b1;
        dmem_wdata = dmem_rdata - 1'b1;
      end
    end else if (r_state == S_IN_WAIT && io.in_valid) begin
      dmem_we    = 1'b1;
      dmem_wdata = io.in_data;
    end
    if (!reset_) dmem_we = 1'b0;
    halted = (r_state == S_HALT);
    error  = (r_state == S_ERR);
  end

  // Pointers, stack pointer, skip depth, error code and handshake registers
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_ip        <= '0;
      r_dp        <= '0;
      r_sp        <= '0;
      r_depth     <= '0;
      r_err_code  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_ip       <= w_ip_nx;
      r_dp       <= w_dp_nx;
      r_depth    <= w_depth_nx;
      r_err_code <= w_err_nx;
      if (w_push)     r_sp <= r_sp + 1'b1;
      else if (w_pop) r_sp <= r_sp - 1'b1;
      if (w_out_set) begin
        r_out_data  <= dmem_rdata;
        r_out_valid <= 1'b1;
      end else if (w_out_clr) begin
        r_out_valid <= 1'b0;
      end
      if (w_in_set)      r_in_ready <= 1'b1;
      else if (w_in_clr) r_in_ready <= 1'b0;
    end
  end

  // Return-stack storage; validity is tracked by r_sp alone
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp[SP_W-2:0]] <= r_ip;
  end

endmodule

// File: tb/tb_bf_core.sv
// Self-checking bench for bf_core: directed timing steps plus random
// programs compared against a plain Brainfuck interpreter.
module tb_bf_core;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned IW = 8;
  localparam int unsigned SD = 16;

  logic          clk = 1'b0;
  logic          reset_ = 1'b0;
  logic [IW-1:0] imem_addr;
  logic [7:0]    imem_data;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_we;
  logic [DW-1:0] dmem_wdata;
  logic          halted, error;
  logic [1:0]    err_code;

  bf_core_if #(.DATA_W(DW)) io ();

  bf_core #(.DATA_W(DW), .DADDR_W(AW), .IADDR_W(IW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset_(reset_),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .io(io.master),
    .halted(halted), .error(error), .err_code(err_code)
  );

  logic [7:0] imem [256];
  logic [7:0] dmem [256];
  logic [7:0] dimg [256];
  logic [7:0] inpool [64];
  logic       ld_en = 1'b0;

  assign imem_data  = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmem_we)    dmem[dmem_addr] <= dmem_wdata;
    else if (ld_en) dmem <= dimg;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference interpreter ----------------
  logic [7:0] m_mem [256];
  logic [7:0] m_out [$];
  int m_ip, m_dp, m_halt, m_err, m_code, m_steps, m_ok;

  task automatic model_run();
    int stk[$];
    int ip, dp, n, nin, d, j;
    logic [7:0] c;
    ip = 0; dp = 0; n = 0; nin = 0;
    m_out.delete();
    m_mem = dimg;
    m_halt = 0; m_err = 0; m_code = 0; m_ok = 1;
    forever begin
      n++;
      if (n > 1500 || nin > 63) begin m_ok = 0; break; end
      c = imem[ip];
      if (c == 8'h00) begin m_halt = 1; break; end
      else if (c == 8'h3E) begin dp = (dp + 1) % 256; ip = (ip + 1) % 256; end
      else if (c == 8'h3C) begin dp = (dp + 255) % 256; ip = (ip + 1) % 256; end
      else if (c == 8'h2B) begin m_mem[dp] = 8'((m_mem[dp] + 1) % 256); ip = (ip + 1) % 256; end
      else if (c == 8'h2D) begin m_mem[dp] = 8'((m_mem[dp] + 255) % 256); ip = (ip + 1) % 256; end
      else if (c == 8'h2E) begin m_out.push_back(m_mem[dp]); ip = (ip + 1) % 256; end
      else if (c == 8'h2C) begin m_mem[dp] = inpool[nin]; nin++; ip = (ip + 1) % 256; end
      else if (c == 8'h5B) begin
        if (m_mem[dp] != 0) begin
          if (stk.size() == SD) begin m_err = 1; m_code = 1; break; end
          stk.push_back(ip); ip = (ip + 1) % 256;
        end else begin
          d = 1; j = ip + 1;
          forever begin
            n++;
            if (imem[j] == 8'h5D && d == 1) begin ip = (j + 1) % 256; break; end
            if (j == 255) begin m_err = 1; m_code = 3; ip = 255; break; end
            if (imem[j] == 8'h5B) d++;
            if (imem[j] == 8'h5D) d--;
            j++;
          end
          if (m_err != 0) break;
        end
      end
      else if (c == 8'h5D) begin
        if (stk.size() == 0) begin m_err = 1; m_code = 2; break; end
        if (m_mem[dp] != 0) ip = (stk[$] + 1) % 256;
        else begin void'(stk.pop_back()); ip = (ip + 1) % 256; end
      end
      else ip = (ip + 1) % 256;
    end
    m_ip = ip; m_dp = dp; m_steps = n;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic load_str(input string s);
    for (int i = 0; i < 256; i++) imem[i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  task automatic do_reset();
    io.out_ready = 1'b0; io.in_valid = 1'b0; io.in_data = '0;
    @(negedge clk); reset_ = 1'b0; ld_en = 1'b1;
    @(negedge clk); ld_en = 1'b0;
    @(negedge clk); reset_ = 1'b1;
  endtask

  logic [7:0] got [$];
  int wr_cnt;

  task automatic run_dut(input int budget, input int ost, input int ist);
    int cyc, nin;
    cyc = 0; nin = 0; wr_cnt = 0;
    got.delete();
    while (!(halted || error) && cyc < budget) begin
      io.out_ready = ($urandom_range(99) >= ost);
      io.in_valid  = ($urandom_range(99) >= ist);
      io.in_data   = inpool[nin % 64];
      #1;
      if (io.out_valid && io.out_ready) got.push_back(io.out_data);
      if (io.in_valid && io.in_ready) nin++;
      if (dmem_we) wr_cnt++;
      @(negedge clk);
      cyc++;
    end
    io.out_ready = 1'b0; io.in_valid = 1'b0;
    chk("finished_in_budget", 32'(halted || error), 32'd1);
  endtask

  task automatic run_prog(input string tag, input int ost, input int ist);
    int mism;
    for (int i = 0; i < 64; i++) inpool[i] = 8'($urandom);
    model_run();
    do_reset();
    run_dut(m_steps * 6 + 300, ost, ist);
    chk({tag, ":halted"}, 32'(halted), 32'(m_halt));
    chk({tag, ":error"}, 32'(error), 32'(m_err));
    chk({tag, ":err_code"}, 32'(err_code), 32'(m_code));
    chk({tag, ":ip"}, 32'(imem_addr), 32'(m_ip));
    chk({tag, ":dp"}, 32'(dmem_addr), 32'(m_dp));
    chk({tag, ":nout"}, 32'(got.size()), 32'(m_out.size()));
    for (int i = 0; i < got.size() && i < m_out.size(); i++)
      chk({tag, ":out"}, 32'(got[i]), 32'(m_out[i]));
    mism = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== m_mem[i]) mism++;
    chk({tag, ":dmem_mismatches"}, 32'(mism), 32'd0);
  endtask

  task automatic clear_dimg(input logic [7:0] c0);
    for (int i = 0; i < 256; i++) dimg[i] = 8'h00;
    dimg[0] = c0;
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    string s;
    string alpha;
    int tries;
    alpha = "+-<>.,[]x";

    // Reset values while reset_ is held low
    clear_dimg(8'h00);
    load_str("+++.");
    do_reset();
    reset_ = 1'b0; #1;
    chk("rst:ip", 32'(imem_addr), 32'd0);
    chk("rst:dp", 32'(dmem_addr), 32'd0);
    chk("rst:out_valid", 32'(io.out_valid), 32'd0);
    chk("rst:in_ready", 32'(io.in_ready), 32'd0);
    chk("rst:out_data", 32'(io.out_data), 32'd0);
    chk("rst:halted", 32'(halted), 32'd0);
    chk("rst:error", 32'(error), 32'd0);
    chk("rst:err_code", 32'(err_code), 32'd0);
    chk("rst:dmem_we", 32'(dmem_we), 32'd0);

    // "+++." with out_ready high: exact edge timing
    do_reset();
    io.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("p1:out_valid_e4", 32'(io.out_valid), 32'd1);
    chk("p1:out_data_e4", 32'(io.out_data), 32'd3);
    chk("p1:ip_e4", 32'(imem_addr), 32'd3);
    @(negedge clk);
    chk("p1:out_valid_e5", 32'(io.out_valid), 32'd0);
    chk("p1:ip_e5", 32'(imem_addr), 32'd4);
    @(negedge clk);
    chk("p1:halted_e6", 32'(halted), 32'd1);
    @(negedge clk);
    chk("p1:ip_frozen", 32'(imem_addr), 32'd4);
    chk("p1:cell", 32'(dmem[0]), 32'd3);
    io.out_ready = 1'b0;

    // Wrap cases and loops through the reference model
    clear_dimg(8'h00);
    load_str("-.");
    run_prog("dec_wrap", 0, 0);
    chk("dec_wrap:value", 32'((got.size() > 0) ? got[0] : 8'h00), 32'hFF);
    load_str("<");
    run_prog("dp_wrap", 0, 0);
    chk("dp_wrap:dp", 32'(dmem_addr), 32'hFF);
    load_str("++[-].");
    run_prog("loop2", 30, 0);
    chk("loop2:ip", 32'(imem_addr), 32'd6);
    load_str("[[+]+].");
    run_prog("skip_nest", 0, 0);
    chk("skip_nest:writes", 32'(wr_cnt), 32'd0);

    // ",." with delayed input and a stalled sink
    clear_dimg(8'h00);
    load_str(",.");
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("io:in_ready_stall", 32'(io.in_ready), 32'd1);
      chk("io:ip_in_stall", 32'(imem_addr), 32'd0);
      if (k < 2) @(negedge clk);
    end
    io.in_valid = 1'b1; io.in_data = 8'h41;
    @(negedge clk);
    io.in_valid = 1'b0;
    chk("io:in_ready_done", 32'(io.in_ready), 32'd0);
    chk("io:ip_after_in", 32'(imem_addr), 32'd1);
    @(negedge clk);
    chk("io:out_valid_stall1", 32'(io.out_valid), 32'd1);
    chk("io:out_data", 32'(io.out_data), 32'h41);
    @(negedge clk);
    chk("io:out_valid_stall2", 32'(io.out_valid), 32'd1);
    chk("io:ip_out_stall", 32'(imem_addr), 32'd1);
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    chk("io:out_valid_done", 32'(io.out_valid), 32'd0);
    chk("io:ip_after_out", 32'(imem_addr), 32'd2);
    chk("io:cell", 32'(dmem[0]), 32'h41);

    // Reset mid-handshake drops out_valid without a clock edge
    load_str("+.");
    do_reset();
    repeat (2) @(negedge clk);
    chk("rst_hs:out_valid_before", 32'(io.out_valid), 32'd1);
    reset_ = 1'b0; #1;
    chk("rst_hs:out_valid", 32'(io.out_valid), 32'd0);

    // Faults
    clear_dimg(8'h01);
    s = "";
    for (int k = 0; k < 17; k++) s = {s, "["};
    load_str(s);
    run_prog("overflow", 0, 0);
    chk("overflow:code", 32'(err_code), 32'd1);
    chk("overflow:ip", 32'(imem_addr), 32'd16);
    clear_dimg(8'h00);
    load_str("[");
    run_prog("skip_wrap", 0, 0);
    chk("skip_wrap:code", 32'(err_code), 32'd3);
    clear_dimg(8'h01);
    load_str("]");
    run_prog("lone_close", 0, 0);
    chk("lone_close:code", 32'(err_code), 32'd2);
    chk("lone_close:error", 32'(error), 32'd1);
    reset_ = 1'b0; #1;
    chk("rst_err:error", 32'(error), 32'd0);
    chk("rst_err:err_code", 32'(err_code), 32'd0);
    chk("rst_err:halted", 32'(halted), 32'd0);
    chk("rst_err:ip", 32'(imem_addr), 32'd0);
    chk("rst_err:dp", 32'(dmem_addr), 32'd0);

    // Random programs over random memory with random handshake stalls
    for (int p = 0; p < 12; p++) begin
      tries = 0;
      do begin
        int len;
        len = $urandom_range(30, 6);
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        for (int i = 0; i < len; i++) imem[i] = alpha[$urandom_range(alpha.len() - 1)];
        for (int i = 0; i < 256; i++) dimg[i] = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(6));
        for (int i = 0; i < 64; i++) inpool[i] = 8'($urandom);
        model_run();
        tries++;
      end while (m_ok == 0 && tries < 50);
      if (m_ok != 0) run_prog($sformatf("rand%0d", p), $urandom_range(60), $urandom_range(60));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/bf_core.md
# bf_core

Parametrised Brainfuck execution core: the successor of the 8-bit processor, now with working loops, handshaked I/O and halt/error reporting. Executes ASCII opcodes fetched from an instruction memory, operates on a data memory of DATA_W-bit cells, and exchanges bytes with the system over valid/ready streams. Sits between the instruction/data memories and the host I/O fabric. Loops are resolved with an internal return stack plus a forward-skip scanner.

## Interface
- DATA_W, 8, cell and I/O width
- DADDR_W, 8, data address width
- IADDR_W, 8, instruction address width
- STACK_DEPTH, 16, maximum nested open loops (power of two)
- clk  in  1  clock, all state on rising edge
- reset_  in  1  asynchronous, active-low reset
- imem_addr  out  IADDR_W  instruction pointer (ip)
- imem_data  in  8  opcode at imem_addr, combinational same cycle
- dmem_addr  out  DADDR_W  data pointer (dp)
- dmem_rdata  in  DATA_W  cell at dmem_addr, combinational same cycle
- dmem_we  out  1  write strobe, memory writes at the next rising edge
- dmem_wdata  out  DATA_W  write value
- out_data  out  DATA_W  output byte, registered
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts
- in_data  in  DATA_W  input byte
- in_valid  in  1  source has data
- in_ready  out  1  core accepting input, registered
- halted  out  1  core stopped on NUL
- error  out  1  core stopped on fault
- err_code  out  2  1=stack overflow, 2=unmatched ']', 3=unterminated '[' skip

## Operation
- States: RUN, SKIP, OUT_WAIT, IN_WAIT, HALT, ERR.
- Opcodes (ASCII): '>' dp+1; '<' dp-1; '+' cell+1; '-' cell-1; '.' output; ',' input; '[' ']' loop; 0x00 halt; any other byte nop (ip+1).
- All ip/dp arithmetic is mod 2^width (wraps); cell arithmetic is mod 2^DATA_W.
- '+'/'-': dmem_we=1, dmem_wdata=dmem_rdata±1, ip+1, all in one cycle.
- '.': out_data<=dmem_rdata, out_valid<=1, go to OUT_WAIT; in OUT_WAIT, on out_valid&&out_ready: out_valid<=0, ip+1, go to RUN.
- ',': in_ready<=1, go to IN_WAIT; in IN_WAIT, on in_valid&&in_ready: dmem_we=1, dmem_wdata=in_data, in_ready<=0, ip+1, go to RUN.
- '[' with cell!=0: push ip, ip+1. If the stack is full: ERR, err_code=1, ip unchanged.
- '[' with cell==0: depth<=1, ip+1, go to SKIP.
- SKIP: per cycle ip+1. '[' increments depth, ']' decrements depth. A ']' at depth 1 returns to RUN. The stack is untouched. If ip would wrap to 0 in SKIP: ERR, err_code=3.
- ']' with cell!=0: ip<=top+1 (stack kept). ']' with cell==0: pop, ip+1. If the stack is empty: ERR, err_code=2.
- NUL: go to HALT, halted=1. ip/dp frozen; exit only by reset.
- ERR: error=1, ip holds the faulting address; exit only by reset.
- dmem_we is combinational: 0 in every state and opcode not listed above, and 0 under reset.

## Timing
- Reset (async, immediate): ip=0, dp=0, stack empty, depth=0, state=RUN, out_valid=0, in_ready=0, out_data=0, halted=0, error=0, err_code=0.
- Reset asserted mid-handshake drops out_valid/in_ready without completing the transfer.
- Execution starts on the first rising edge after reset_ deasserts.
- Latency:
  - '>' '<' '+' '-' '[' ']' and nop: 1 cycle each.
  - Each SKIP step: 1 cycle.
  - '.': 1 cycle plus the cycles until acceptance. Minimum 2 when out_ready is held high.
  - ',': 1 cycle plus the cycles until in_valid. Minimum 2.
- out_valid, once set, holds with out_data stable until accepted.
- in_ready holds until in_valid is seen.
- A push/pop and the ip update commit on the same edge. There is no bubble after a jump.

## Test plan
- Program "+++.": reset, out_ready=1 -> out_data=3 with out_valid for 1 cycle; ip=4 on the 5th edge; NUL at 4 -> halted=1.
- "-." on a zero cell, DATA_W=8 -> out_data=0xFF (wrap). "<" from dp=0 -> dmem_addr=0xFF.
- "++[-]." -> the loop runs 2 iterations, output 0; ip after the loop = 5; stack empty at halt.
- "[[+]+]." with cell=0 -> SKIP over both nests (depth reaches 2), no data write occurs, output 0.
- ",." with in_valid delayed 3 cycles and out_ready low 2 cycles: in_data=0x41 -> out_data=0x41. in_ready and out_valid stay high through the stalls, and ip advances only on the handshake cycles.
- Faults:
  - 17 nested '[' with cell=1, STACK_DEPTH=16 -> error=1, err_code=1, ip=16.
  - Lone ']' with cell=1 -> err_code=2.
  - Reset during ERR -> all outputs return to their reset values.
